// File: rtl/tinyriscv_pkg.sv
// Shared definitions for tinyriscv RIB peripherals: interrupt codes, bus
// payload, timer register map, CTRL bit positions and the slave-port FSM states.
package tinyriscv_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INT_W  = 8;

  // Interrupt encoding
  localparam logic [INT_W-1:0] INT_NONE     = 8'h00;
  localparam logic [INT_W-1:0] INT_TIMER0   = 8'h01;
  localparam logic             INT_ASSERT   = 1'b1;
  localparam logic             INT_DEASSERT = 1'b0;

  // RIB handshake levels
  localparam logic RIB_REQ     = 1'b1;
  localparam logic WriteEnable = 1'b1;

  // Timer register offsets (addr[3:2])
  localparam logic [1:0] TIMER_CTRL  = 2'd0;
  localparam logic [1:0] TIMER_COUNT = 2'd1;
  localparam logic [1:0] TIMER_VALUE = 2'd2;

  // CTRL bit indices
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_IE   = 1;
  localparam int unsigned CTRL_PEND = 2;

  // Request payload as seen by a RIB slave
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } rib_req_t;

  // Slave-port handshake states
  typedef enum logic [0:0] {
    RIB_IDLE = 1'b0,
    RIB_RESP = 1'b1
  } rib_state_e;

  // Pack CTRL fields into a read word; unused bits read 0
  function automatic logic [DATA_W-1:0] ctrl_word(input logic en, input logic ie,
                                                  input logic pend);
    logic [DATA_W-1:0] w;
    w            = '0;
    w[CTRL_EN]   = en;
    w[CTRL_IE]   = ie;
    w[CTRL_PEND] = pend;
    return w;
  endfunction

endpackage

// File: rtl/rib_slave_port.sv
// Generic RIB slave handshake: accepts a request in IDLE, then presents a
// one-cycle ack with the read data captured at acceptance.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req        - request from initiator
//   rdata      - combinational read data from the peripheral register file
//   accept_c   - combinational strobe: request accepted this cycle
//   ack        - registered response strobe (one cycle)
//   data       - registered read data, zero when ack is low
module rib_slave_port
  import tinyriscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] rdata,
  output logic              accept_c,
  output logic              ack,
  output logic [DATA_W-1:0] data
);

  rib_state_e        state;
  rib_state_e        state_nxt;
  logic              ack_nxt;
  logic [DATA_W-1:0] data_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RIB_IDLE;
      ack   <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_nxt;
      ack   <= ack_nxt;
      data  <= data_nxt;
    end
  end

  // Next state; RESP always falls back to IDLE so requests ack every other cycle
  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    data_nxt  = '0;
    accept_c  = 1'b0;
    case (state)
      RIB_IDLE: begin
        if (req == RIB_REQ) begin
          accept_c  = 1'b1;
          state_nxt = RIB_RESP;
          ack_nxt   = 1'b1;
          data_nxt  = rdata;
        end
      end
      RIB_RESP: state_nxt = RIB_IDLE;
      default:  state_nxt = RIB_IDLE;
    endcase
  end

endmodule

// File: rtl/rib_timer.sv
// RIB timer peripheral: CTRL/COUNT/VALUE registers, periodic counter with
// pending flag and registered interrupt output.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req_i, we_i          - RIB request and write enable
//   addr_i, data_i       - byte address (bits [3:2] decoded), write data
//   data_o, ack_o        - read data and one-cycle response strobe
//   int_sig_o, int_o     - interrupt level and interrupt code
module rib_timer
  import tinyriscv_pkg::*;
#(
  parameter logic [INT_W-1:0] IntId = INT_TIMER0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_o,
  output logic              int_sig_o,
  output logic [INT_W-1:0]  int_o
);

  rib_req_t          bus_c;
  logic              accept_c;
  logic [DATA_W-1:0] rdata_c;
  logic              wr_ctrl_c;
  logic              wr_value_c;
  logic              hit_c;

  logic              en;
  logic              ie;
  logic              pend;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] value;

  logic unused_addr;
  assign unused_addr = ^{bus_c.addr[ADDR_W-1:4], bus_c.addr[1:0]};

  assign bus_c = '{we: we_i, addr: addr_i, wdata: data_i};

  rib_slave_port u_port (
    .clk      (clk),
    .rst      (rst),
    .req      (req_i),
    .rdata    (rdata_c),
    .accept_c (accept_c),
    .ack      (ack_o),
    .data     (data_o)
  );

  assign wr_ctrl_c  = accept_c & (bus_c.we == WriteEnable) & (bus_c.addr[3:2] == TIMER_CTRL);
  assign wr_value_c = accept_c & (bus_c.we == WriteEnable) & (bus_c.addr[3:2] == TIMER_VALUE);

  // Terminal count; VALUE==0 means free-run with no match
  assign hit_c = en & (value != '0) & (count == value - DATA_W'(1));

  // Read mux, pre-write values of the accepting cycle
  always_comb begin
    rdata_c = '0;
    case (bus_c.addr[3:2])
      TIMER_CTRL:  rdata_c = ctrl_word(en, ie, pend);
      TIMER_COUNT: rdata_c = count;
      TIMER_VALUE: rdata_c = value;
      default:     rdata_c = '0;
    endcase
  end

  // Timer registers and interrupt outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      ie        <= 1'b0;
      pend      <= 1'b0;
      count     <= '0;
      value     <= '0;
      int_sig_o <= INT_DEASSERT;
      int_o     <= INT_NONE;
    end else begin
      if (wr_ctrl_c) begin
        en <= bus_c.wdata[CTRL_EN];
        ie <= bus_c.wdata[CTRL_IE];
      end
      // Hardware set beats a simultaneous write-1-to-clear
      if (hit_c) begin
        pend <= 1'b1;
      end else if (wr_ctrl_c && bus_c.wdata[CTRL_PEND]) begin
        pend <= 1'b0;
      end
      if (wr_value_c) begin
        value <= bus_c.wdata;
      end
      if (!en || hit_c) begin
        count <= '0;
      end else begin
        count <= count + DATA_W'(1);
      end
      int_sig_o <= (pend & ie) ? INT_ASSERT : INT_DEASSERT;
      int_o     <= (pend & ie) ? IntId : INT_NONE;
    end
  end

endmodule

// File: tb/tb_rib_timer.sv
// Randomized scoreboard bench for rib_timer with a transaction-level model.
module tb_rib_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        int_sig_o;
  logic [7:0]  int_o;

  always #5 clk = ~clk;

  rib_timer #(.IntId(8'h01)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .ack_o     (ack_o),
    .int_sig_o (int_sig_o),
    .int_o     (int_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acks   = 0;

  // Reference state
  bit          m_en, m_ie, m_pend, m_busy, m_int;
  int unsigned m_count, m_value;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t expq[$];

  // Advance the model by one clock edge using the inputs held at that edge
  task automatic step();
    logic [31:0] regs [4];
    bit          acc;
    bit          wrap;
    longint      nxt;
    exp_t        e;
    if (rst) begin
      m_en = 0; m_ie = 0; m_pend = 0; m_busy = 0; m_int = 0;
      m_count = 0; m_value = 0;
      return;
    end
    regs[0] = {29'd0, m_pend, m_ie, m_en};
    regs[1] = m_count;
    regs[2] = m_value;
    regs[3] = 32'd0;
    acc = req_i && !m_busy;
    if (acc) begin
      e.cyc  = cyc;
      e.data = regs[addr_i[3:2]];
      expq.push_back(e);
    end
    m_int = m_pend && m_ie;
    wrap  = 0;
    if (!m_en) m_count = 0;
    else begin
      nxt = longint'(m_count) + 1;
      if (m_value != 0 && nxt == longint'(m_value)) begin
        wrap = 1;
        nxt  = 0;
      end
      m_count = 32'(nxt);
    end
    if (acc && we_i && addr_i[3:2] == 2'd0) begin
      m_en = data_i[0];
      m_ie = data_i[1];
      if (data_i[2]) m_pend = 0;
    end
    if (wrap) m_pend = 1;
    if (acc && we_i && addr_i[3:2] == 2'd2) m_value = data_i;
    m_busy = acc;
  endtask

  task automatic drive(input bit r, input bit rq, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    rst = r; req_i = rq; we_i = w; addr_i = a; data_i = d;
    @(posedge clk);
    cyc++;
    step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(0, 1, 1, a, d);
    idle(1);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(0, 1, 0, a, 32'h0);
    idle(1);
  endtask

  // Monitor: pops expected responses whenever the DUT acks
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        checks++; errors++;
        e = expq.pop_front();
        $display("FAIL missing_ack: no ack for request accepted at cycle %0d (now %0d)", e.cyc, cyc);
      end
      if (ack_o === 1'b1) begin
        acks++;
        checks++;
        if (expq.size() == 0 || expq[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_ack: ack at cycle %0d with no matching request", cyc);
        end else begin
          e = expq.pop_front();
          if (data_o !== e.data) begin
            errors++;
            $display("FAIL read_data: cycle %0d got %h expected %h", cyc, data_o, e.data);
          end
        end
      end else begin
        checks++;
        if (ack_o !== 1'b0 || data_o !== 32'h0) begin
          errors++;
          $display("FAIL idle_bus: cycle %0d ack %b data %h expected ack 0 data 0", cyc, ack_o, data_o);
        end
      end
      checks++;
      if (int_sig_o !== m_int || int_o !== (m_int ? 8'h01 : 8'h00)) begin
        errors++;
        $display("FAIL interrupt: cycle %0d int_sig %b int %h expected %b %h",
                 cyc, int_sig_o, int_o, m_int, m_int ? 8'h01 : 8'h00);
      end
    end
  end

  initial begin
    int a0;
    int n;
    bit found;
    rst = 1; req_i = 0; we_i = 0; addr_i = 0; data_i = 0;
    drive(1, 0, 0, 32'h0, 32'h0);
    drive(1, 1, 1, 32'h0, 32'h7);
    idle(1);

    // Reset values readable
    rd(32'h0); rd(32'h4); rd(32'h8);

    // Period-5 timer with interrupt
    wr(32'h8, 32'd5);
    wr(32'h0, 32'h3);
    idle(14);
    rd(32'h0); rd(32'h4);

    // Clear PEND, then W1C colliding with the hardware set
    wr(32'h0, 32'h7);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (!m_busy && m_en && m_count + 1 == m_value) found = 1;
      else idle(1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL align_timeout: could not align W1C with terminal count");
    end
    wr(32'h0, 32'h7);
    rd(32'h0);
    idle(2);
    wr(32'h0, 32'h7);
    idle(3);

    // Held request acks every other cycle
    a0 = acks;
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 32'h4, 32'h0);
    idle(2);
    checks++;
    if (acks - a0 != 3) begin
      errors++;
      $display("FAIL back_to_back: got %0d acks expected 3", acks - a0);
    end

    // Unmapped offset and read-only COUNT
    wr(32'hC, 32'hDEADBEEF);
    rd(32'hC);
    wr(32'h4, 32'h0000_0123);
    rd(32'h4);
    rd(32'h8);

    // Reset during the response cycle
    wr(32'h8, 32'd3);
    drive(0, 1, 0, 32'h8, 32'h0);
    drive(1, 1, 0, 32'h8, 32'h0);
    idle(1);
    rd(32'h0); rd(32'h4); rd(32'h8);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a, d;
      a = {$urandom} & 32'hFFFF_FFF3;
      a[3:2] = 2'($urandom_range(0, 3));
      n = $urandom_range(0, 9);
      if (a[3:2] == 2'd2 && n < 8) d = 32'($urandom_range(0, 12));
      else if (a[3:2] == 2'd0 && n < 8) d = 32'($urandom_range(0, 7));
      else d = $urandom;
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
            $urandom_range(0, 1) == 1, a, d);
    end

    idle(3);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected responses never acked expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rib_timer.md
RIB_TIMER -- requirements
Module: rib_timer

Interface
REQ-001 SHALL have parameter IntId, default INT_TIMER0, interrupt code driven on int_o when the interrupt is asserted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high (does not use RstEnable polarity).
REQ-004 SHALL have port req_i  input  1  RIB request (RIB_REQ) from the core-side initiator.
REQ-005 SHALL have port we_i  input  1  write enable (WriteEnable = write); sampled with req_i.
REQ-006 SHALL have port addr_i  input  32  byte address; only addr_i[3:2] are decoded.
REQ-007 SHALL have port data_i  input  32  write data.
REQ-008 SHALL have port data_o  output  32  read data; valid only while ack_o=1.
REQ-009 SHALL have port ack_o  output  1  one-cycle response strobe per accepted request.
REQ-010 SHALL have port int_sig_o  output  1  interrupt level (INT_ASSERT/INT_DEASSERT).
REQ-011 SHALL have port int_o  output  8  IntId while int_sig_o=1, else INT_NONE.

Function
REQ-012 SHALL hold registers: CTRL (addr_i[3:2]=0: bit0 EN, bit1 IE, bit2 PEND; other bits read 0), COUNT (=1, read-only), VALUE (=2, read/write).
REQ-013 SHALL implement handshake FSM with states IDLE and RESP.
REQ-014 IDLE: if req_i=1, SHALL accept the request, perform any write, register read data, and move to RESP; else stay IDLE.
REQ-015 RESP: SHALL assert ack_o=1 with data_o valid for exactly one cycle, then return to IDLE unconditionally.
REQ-016 A req_i asserted in RESP SHALL NOT be accepted until the next IDLE cycle (back-to-back requests ack every other cycle).
REQ-017 data_o SHALL be 0 whenever ack_o=0.
REQ-018 Read data SHALL reflect register values as of the accepting (IDLE) cycle.
REQ-019 Unmapped offset (addr_i[3:2]=3) SHALL be acked, read 0, write ignored; writes to COUNT SHALL be ignored.
REQ-020 With EN=1 and VALUE!=0, COUNT SHALL increment by 1 per cycle; when COUNT==VALUE-1, next cycle COUNT SHALL become 0 and PEND SHALL be set.
REQ-021 With EN=1 and VALUE=0, COUNT SHALL free-run and wrap 0xFFFF_FFFF->0 without setting PEND.
REQ-022 With EN=0, COUNT SHALL be held at 0; a write clearing EN SHALL zero COUNT on the following cycle.
REQ-023 CTRL write SHALL update EN/IE from data_i[1:0]; data_i[2]=1 SHALL clear PEND (write-1-to-clear), data_i[2]=0 leaves PEND.
REQ-024 If hardware sets PEND in the same cycle as a W1C, set SHALL win.
REQ-025 A VALUE write SHALL take effect for the compare in the cycle after acceptance; if new VALUE <= current COUNT, COUNT SHALL run to wrap before matching.
REQ-026 int_sig_o SHALL equal PEND & IE, registered (one cycle after PEND/IE change).

Reset
REQ-027 On rst=1 at a clock edge: FSM=IDLE, ack_o=0, data_o=0, CTRL=0, COUNT=0, VALUE=0, int_sig_o=0, int_o=INT_NONE.
REQ-028 rst during RESP SHALL abort the response; no ack_o pulse SHALL follow reset.

Structure
REQ-029 Register offsets (TIMER_CTRL, TIMER_COUNT, TIMER_VALUE) and CTRL bit indices SHALL be added to tinyriscv_pkg; the FSM state enum SHALL be a package typedef.
REQ-030 The IDLE/RESP handshake SHALL be a sub-module rib_slave_port, reusable by other RIB peripherals.

Verification
REQ-031 Reset then read CTRL/COUNT/VALUE -> each acked one cycle after accept, data_o=0.
REQ-032 Write VALUE=5, CTRL=0x3 -> COUNT 0..4 repeats; PEND set on wrap, int_sig_o=1 next cycle, int_o=0x01.
REQ-033 Write CTRL=0x7 in same cycle PEND sets -> PEND stays 1; CTRL=0x7 later -> int_sig_o drops one cycle after PEND clears.
REQ-034 req_i held high 6 cycles -> exactly 3 ack_o pulses, alternating cycles.
REQ-035 Write addr 0xC with 0xDEADBEEF, read back -> ack, data 0; write COUNT -> unchanged.
REQ-036 rst asserted in RESP -> no ack_o, all registers 0 next cycle.
